// File: rtl/adder_with_carry_pkg.sv
// Shared constants for the registered ripple-carry adder.
package adder_with_carry_pkg;

  localparam int WIDTH_DEFAULT = 4;

endpackage

// File: rtl/adder_with_carry_full_adder.sv
// One-bit full adder cell used to build the ripple chain.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/adder_with_carry.sv
// Ripple-carry adder with carry-in, registered sum/carry-out and a signed
// negative-overflow flag. One cycle of latency; synchronous active-high reset.
module adder_with_carry
  import adder_with_carry_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] s,
  output logic             bout,
  output logic             underflow
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_c;
  logic             underflow_c;

  assign carry[0] = bin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .x    (a[i]),
      .y    (b[i]),
      .cin  (carry[i]),
      .sum  (sum_c[i]),
      .cout (carry[i+1])
    );
  end

  // Two negatives whose sum lands non-negative means it wrapped below -2^(WIDTH-1).
  assign underflow_c = a[WIDTH-1] & b[WIDTH-1] & ~sum_c[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      s         <= '0;
      bout      <= 1'b0;
      underflow <= 1'b0;
    end else begin
      s         <= sum_c;
      bout      <= carry[WIDTH];
      underflow <= underflow_c;
    end
  end

endmodule

// File: tb/tb_adder_with_carry.sv
// Self-checking bench for adder_with_carry: directed corners, exhaustive sweep
// and random stimulus with mid-stream resets against an arithmetic model.
module tb_adder_with_carry;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a, b;
  logic         bin;
  logic [W-1:0] s;
  logic         bout;
  logic         underflow;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adder_with_carry #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .s         (s),
    .bout      (bout),
    .underflow (underflow)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {underflow, bout, s} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic r, input logic [W-1:0] av,
                                          input logic [W-1:0] bv, input logic cv);
    int   u, sa, sb;
    logic uf;
    if (r) return '0;
    u  = int'(av) + int'(bv) + int'(cv);
    sa = av[W-1] ? int'(av) - (1 << W) : int'(av);
    sb = bv[W-1] ? int'(bv) - (1 << W) : int'(bv);
    uf = ((sa + sb + int'(cv)) < -(1 << (W-1)));
    return {uf, u[W], u[W-1:0]};
  endfunction

  // Drive one operation, check one cycle later, then scramble the inputs and
  // confirm the registered outputs do not move before the next edge.
  task automatic apply(input logic r, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic cv, input string tag);
    logic [W+1:0] exp;
    rst = r; a = av; b = bv; bin = cv;
    exp = model(r, av, bv, cv);
    @(posedge clk);
    #1;
    check_val({tag, "_s"},  32'(s),         32'(exp[W-1:0]));
    check_val({tag, "_co"}, 32'(bout),      32'(exp[W]));
    check_val({tag, "_uf"}, 32'(underflow), 32'(exp[W+1]));
    a   = W'($urandom);
    b   = W'($urandom);
    bin = 1'($urandom);
    rst = 1'b0;
    #2;
    check_val({tag, "_hold"}, 32'({underflow, bout, s}), 32'(exp));
  endtask

  initial begin
    rst = 1'b1; a = '0; b = '0; bin = 1'b0;

    apply(1'b1, 4'hF, 4'hF, 1'b1, "reset");
    apply(1'b0, 4'b0111, 4'b0001, 1'b0, "pos_ovf");
    apply(1'b0, 4'b1000, 4'b1000, 1'b0, "neg_ovf");
    apply(1'b0, 4'b1111, 4'b0001, 1'b0, "wrap");
    apply(1'b0, 4'b0101, 4'b1101, 1'b1, "cin");
    apply(1'b0, 4'b1111, 4'b0000, 1'b1, "ones_cin");
    apply(1'b0, 4'b0000, 4'b0000, 1'b0, "zero");

    // Reset between two operations discards the pending result.
    apply(1'b0, 4'b1001, 4'b1010, 1'b1, "pre_rst");
    apply(1'b1, 4'b1001, 4'b1010, 1'b1, "mid_rst");
    apply(1'b0, 4'b1001, 4'b1010, 1'b1, "post_rst");

    for (int i = 0; i < (1 << (2*W+1)); i++) begin
      logic [2*W:0] v;
      v = (2*W+1)'(i);
      apply(1'b0, v[W-1:0], v[2*W-1:W], v[2*W], "exh");
    end

    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 9) == 0), W'($urandom), W'($urandom), 1'($urandom), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
